pixel_diff_scan_ctrl: RTL and testbench

- Multi-cycle custom-instruction engine that counts differing pixels between two greyscale image regions in memory.
- Software programs base addresses A and B, then issues one START instruction with a word count.
- The block fetches words alternately from A and B over a single-outstanding bus-read port and compares four 8-bit pixels per word pair.
- It accumulates the number of unequal bytes and returns the total in ciResult when the scan completes.

---
 rtl/pixel_diff_scan_ctrl_if.sv | 29 ++
 rtl/pixel_diff_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_pixel_diff_scan_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_diff_scan_ctrl_if.sv
// Bus bundles for the pixel difference scanner: CPU custom-instruction port
// and the single-outstanding memory read port.
interface pixel_diff_ci_if;
  logic        ciStart;
  logic        ciCke;
  logic [7:0]  ciN;
  logic [31:0] ciValueA;
  logic [31:0] ciValueB;
  logic        ciDone;
  logic [31:0] ciResult;

  modport master (output ciStart, ciCke, ciN, ciValueA, ciValueB,
                  input  ciDone, ciResult);
  modport slave  (input  ciStart, ciCke, ciN, ciValueA, ciValueB,
                  output ciDone, ciResult);
endinterface

interface pixel_diff_mem_if;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memGrant;
  logic        memRdValid;
  logic [31:0] memRdData;

  modport master (output memReq, memAddr,
                  input  memGrant, memRdValid, memRdData);
  modport slave  (input  memReq, memAddr,
                  output memGrant, memRdValid, memRdData);
endinterface

// File: rtl/pixel_diff_scan_ctrl.sv
// Custom-instruction engine: fetches word pairs alternately from regions A and B
// and counts the byte lanes that differ, returning the total on completion.
module pixel_diff_scan_ctrl #(
  parameter logic [7:0]  customId       = 8'h00,
  parameter int unsigned MAX_WORDS_BITS = 16
) (
  input  logic             clock,
  input  logic             reset,
  pixel_diff_ci_if.slave   ci,
  pixel_diff_mem_if.master mem
);

  localparam int unsigned ACC_W = MAX_WORDS_BITS + 2;

  typedef enum logic [2:0] {
    IDLE,
    REQ_A,
    WAIT_A,
    REQ_B,
    WAIT_B,
    ACC,
    FINISH
  } state_t;

  state_t                    state;
  logic [31:0]               base_a;
  logic [31:0]               base_b;
  logic [31:0]               ptr_a;
  logic [31:0]               ptr_b;
  logic [MAX_WORDS_BITS-1:0] remaining;
  logic [ACC_W-1:0]          acc;
  logic [31:0]               last_result;
  logic [31:0]               word_a;
  logic [31:0]               word_b;
  logic                      mem_req;
  logic [31:0]               mem_addr;

  logic        mine;
  logic [1:0]  op;
  logic        imm_done;
  logic [2:0]  diff_cnt;
  logic        done;
  logic [31:0] result;
  logic        unused_value_a;

  assign mine           = ci.ciStart & ci.ciCke & (ci.ciN == customId);
  assign op             = ci.ciValueA[1:0];
  assign unused_value_a = ^ci.ciValueA[31:2];

  // Register/readback opcodes answer in the same cycle, but only while idle.
  assign imm_done = mine && (state == IDLE) && (op != 2'd2);

  always_comb begin
    diff_cnt = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (word_a[8*i +: 8] != word_b[8*i +: 8]) diff_cnt = diff_cnt + 3'd1;
    end
  end

  always_comb begin
    done   = imm_done || (state == FINISH);
    result = '0;
    if (state == FINISH)             result = 32'(acc);
    else if (imm_done && op == 2'd3) result = last_result;
  end

  assign ci.ciDone   = done;
  assign ci.ciResult = result;
  assign mem.memReq  = mem_req;
  assign mem.memAddr = mem_addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      base_a      <= '0;
      base_b      <= '0;
      ptr_a       <= '0;
      ptr_b       <= '0;
      remaining   <= '0;
      acc         <= '0;
      last_result <= '0;
      word_a      <= '0;
      word_b      <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mine) begin
            case (op)
              2'd0: base_a <= {ci.ciValueB[31:2], 2'b00};
              2'd1: base_b <= {ci.ciValueB[31:2], 2'b00};
              2'd2: begin
                remaining <= ci.ciValueB[MAX_WORDS_BITS-1:0];
                ptr_a     <= base_a;
                ptr_b     <= base_b;
                acc       <= '0;
                if (ci.ciValueB[MAX_WORDS_BITS-1:0] == '0) begin
                  state <= FINISH;
                end else begin
                  state    <= REQ_A;
                  mem_req  <= 1'b1;
                  mem_addr <= base_a;
                end
              end
              default: ;
            endcase
          end
        end
        REQ_A: begin
          if (mem.memGrant) begin
            mem_req <= 1'b0;
            state   <= WAIT_A;
          end
        end
        WAIT_A: begin
          if (mem.memRdValid) begin
            word_a   <= mem.memRdData;
            mem_req  <= 1'b1;
            mem_addr <= ptr_b;
            state    <= REQ_B;
          end
        end
        REQ_B: begin
          if (mem.memGrant) begin
            mem_req <= 1'b0;
            state   <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (mem.memRdValid) begin
            word_b <= mem.memRdData;
            state  <= ACC;
          end
        end
        ACC: begin
          acc       <= acc + ACC_W'(diff_cnt);
          ptr_a     <= ptr_a + 32'd4;
          ptr_b     <= ptr_b + 32'd4;
          remaining <= remaining - MAX_WORDS_BITS'(1);
          if (remaining == MAX_WORDS_BITS'(1)) begin
            state <= FINISH;
          end else begin
            state    <= REQ_A;
            mem_req  <= 1'b1;
            mem_addr <= ptr_a + 32'd4;
          end
        end
        FINISH: begin
          last_result <= 32'(acc);
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_diff_scan_ctrl.sv
// Self-checking bench for pixel_diff_scan_ctrl: memory responder with configurable
// grant/valid delays, reference diff count computed directly from the memory image.
module tb_pixel_diff_scan_ctrl;

  localparam logic [7:0] CID = 8'h5A;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pixel_diff_ci_if  ci_bus ();
  pixel_diff_mem_if mem_bus ();

  pixel_diff_scan_ctrl #(.customId(CID), .MAX_WORDS_BITS(16)) dut (
    .clock (clock),
    .reset (reset),
    .ci    (ci_bus),
    .mem   (mem_bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] addr_log [$];

  // Observations collected by run_scan
  bit          scan_done;
  int          scan_lat;
  logic [31:0] scan_res;
  int          scan_stall;
  int          scan_stray;
  bit          scan_inj_done;
  int          scan_post;
  logic        scan_done_after;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 32'h0;
  endfunction

  function automatic int ref_diff(input logic [31:0] ba, input logic [31:0] bb, input int unsigned n);
    int total = 0;
    logic [31:0] wa, wb;
    for (int unsigned i = 0; i < n; i++) begin
      wa = rd(ba + 32'(4 * i));
      wb = rd(bb + 32'(4 * i));
      for (int k = 0; k < 4; k++)
        if (((wa >> (8 * k)) & 32'hFF) != ((wb >> (8 * k)) & 32'hFF)) total++;
    end
    return total;
  endfunction

  function automatic int ref_latency(input int unsigned n, input int g, input int v);
    return (n == 0) ? 1 : int'(n) * (2 * (g + 1 + v) + 1) + 1;
  endfunction

  function automatic int addr_mismatches(input logic [31:0] ba, input logic [31:0] bb, input int unsigned n);
    int bad = 0;
    logic [31:0] e;
    if (addr_log.size() != int'(2 * n)) return 9999;
    for (int unsigned i = 0; i < 2 * n; i++) begin
      e = (i % 2 == 0) ? ba + 32'(4 * (i / 2)) : bb + 32'(4 * (i / 2));
      if (addr_log[i] !== e) bad++;
    end
    return bad;
  endfunction

  task automatic fill_random(input logic [31:0] ba, input logic [31:0] bb, input int unsigned n);
    logic [31:0] a, b;
    for (int unsigned i = 0; i < n; i++) begin
      a = $urandom;
      b = a;
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 1) == 1) b[8*k +: 8] = a[8*k +: 8] ^ 8'($urandom_range(1, 255));
      mem_model[ba + 32'(4 * i)] = a;
      mem_model[bb + 32'(4 * i)] = b;
    end
  endtask

  task automatic idle_inputs();
    ci_bus.ciStart      = 1'b0;
    ci_bus.ciCke        = 1'b1;
    ci_bus.ciN          = 8'($urandom);
    ci_bus.ciValueA     = $urandom;
    ci_bus.ciValueB     = $urandom;
    mem_bus.memGrant    = 1'b0;
    mem_bus.memRdValid  = 1'b0;
    mem_bus.memRdData   = $urandom;
  endtask

  // One custom-instruction cycle; returns done/result sampled mid-cycle.
  task automatic ci_cmd(input logic [7:0] n, input logic cke, input logic [1:0] op,
                        input logic [31:0] vb, output logic done, output logic [31:0] res);
    @(negedge clock);
    idle_inputs();
    ci_bus.ciStart  = 1'b1;
    ci_bus.ciCke    = cke;
    ci_bus.ciN      = n;
    ci_bus.ciValueA = {30'($urandom), op};
    ci_bus.ciValueB = vb;
    #1;
    done = ci_bus.ciDone;
    res  = ci_bus.ciResult;
    @(posedge clock);
    #1;
    ci_bus.ciStart = 1'b0;
  endtask

  task automatic run_scan(input int unsigned n, input int gdelay, input int vdelay,
                          input bit inject, input bit abort, input int budget);
    int req_wait = 0, vcnt = 0, b_cyc = -10, abort_cyc = -10;
    bit pending = 0, req_active = 0;
    logic [31:0] paddr = '0, addr0 = '0;
    scan_done = 0; scan_lat = -1; scan_res = '0; scan_stall = 0; scan_stray = 0;
    scan_inj_done = 0; scan_post = 0; scan_done_after = 1'b0;
    addr_log.delete();
    @(negedge clock);
    idle_inputs();
    ci_bus.ciStart  = 1'b1;
    ci_bus.ciN      = CID;
    ci_bus.ciValueA = {30'($urandom), 2'd2};
    ci_bus.ciValueB = {16'($urandom), 16'(n)};
    #1;
    if (ci_bus.ciDone !== 1'b0 || ci_bus.ciResult !== 32'h0) scan_stray++;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clock);
      idle_inputs();
      reset = 1'b0;
      if (pending) begin
        vcnt--;
        if (vcnt == 0) begin
          mem_bus.memRdValid = 1'b1;
          mem_bus.memRdData  = rd(paddr);
          pending = 0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        mem_bus.memRdValid = 1'b1;
      end
      if (mem_bus.memReq === 1'b1) begin
        if (!req_active) begin
          req_active = 1; addr0 = mem_bus.memAddr; req_wait = 0;
        end else if (mem_bus.memAddr !== addr0) begin
          scan_stall++;
        end
        if (req_wait >= gdelay) begin
          mem_bus.memGrant = 1'b1;
          addr_log.push_back(mem_bus.memAddr);
          paddr = mem_bus.memAddr; pending = 1; vcnt = vdelay; req_active = 0;
          if (addr_log.size() == 2 && b_cyc < 0) b_cyc = cyc;
        end else begin
          req_wait++;
        end
      end else if (req_active) begin
        scan_stall++; req_active = 0;
      end
      if (inject && cyc == b_cyc + 1) begin
        ci_bus.ciStart  = 1'b1;
        ci_bus.ciN      = CID;
        ci_bus.ciValueA = {30'($urandom), 2'd0};
        ci_bus.ciValueB = 32'h0000_5000;
      end
      if (abort && cyc == b_cyc + 2) begin
        reset = 1'b1; abort_cyc = cyc;
      end
      #1;
      if (abort_cyc > 0 && cyc > abort_cyc) begin
        if (mem_bus.memReq !== 1'b0 || ci_bus.ciDone !== 1'b0) scan_post++;
        if (cyc >= abort_cyc + 6) break;
        continue;
      end
      if (ci_bus.ciDone === 1'b1) begin
        if (inject && cyc == b_cyc + 1) scan_inj_done = 1;
        else begin
          scan_done = 1; scan_lat = cyc; scan_res = ci_bus.ciResult;
        end
      end else if (ci_bus.ciResult !== 32'h0) begin
        scan_stray++;
      end
      if (scan_done) begin
        @(negedge clock);
        idle_inputs();
        #1;
        scan_done_after = ci_bus.ciDone;
        break;
      end
    end
    @(negedge clock);
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic d; logic [31:0] r;
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (mem_bus.memReq !== 1'b0) begin errors++; $display("FAIL reset_memReq: got %b expected 0", mem_bus.memReq); end
    checks++; if (mem_bus.memAddr !== 32'h0) begin errors++; $display("FAIL reset_memAddr: got %h expected 0", mem_bus.memAddr); end
    checks++; if (ci_bus.ciDone !== 1'b0) begin errors++; $display("FAIL reset_ciDone: got %b expected 0", ci_bus.ciDone); end
    checks++; if (ci_bus.ciResult !== 32'h0) begin errors++; $display("FAIL reset_ciResult: got %h expected 0", ci_bus.ciResult); end
    reset = 1'b0;
    ci_cmd(CID, 1'b1, 2'd3, $urandom, d, r);
    checks++; if (d !== 1'b1 || r !== 32'h0) begin errors++; $display("FAIL reset_read: got done=%b res=%h expected done=1 res=0", d, r); end
  endtask

  task automatic test_set_regs();
    logic d; logic [31:0] r; int req_seen = 0;
    ci_cmd(CID, 1'b1, 2'd0, 32'h0000_1000, d, r);
    checks++; if (d !== 1'b1 || r !== 32'h0) begin errors++; $display("FAIL set_a: got done=%b res=%h expected done=1 res=0", d, r); end
    ci_cmd(CID, 1'b1, 2'd1, 32'h0000_2000, d, r);
    checks++; if (d !== 1'b1 || r !== 32'h0) begin errors++; $display("FAIL set_b: got done=%b res=%h expected done=1 res=0", d, r); end
    ci_cmd(CID ^ 8'h01, 1'b1, 2'd2, 32'd5, d, r);
    checks++; if (d !== 1'b0 || r !== 32'h0) begin errors++; $display("FAIL wrong_id: got done=%b res=%h expected done=0 res=0", d, r); end
    ci_cmd(CID, 1'b0, 2'd3, 32'd0, d, r);
    checks++; if (d !== 1'b0 || r !== 32'h0) begin errors++; $display("FAIL cke_low: got done=%b res=%h expected done=0 res=0", d, r); end
    repeat (4) begin
      @(negedge clock);
      if (mem_bus.memReq !== 1'b0) req_seen++;
    end
    checks++; if (req_seen != 0) begin errors++; $display("FAIL set_no_req: got %0d memReq cycles expected 0", req_seen); end
  endtask

  task automatic test_single_word();
    logic d; logic [31:0] r; int am;
    mem_model[32'h1000] = 32'h1122_3344;
    mem_model[32'h2000] = 32'h11FF_3300;
    run_scan(1, 0, 1, 0, 0, 40);
    am = addr_mismatches(32'h1000, 32'h2000, 1);
    checks++; if (am != 0) begin errors++; $display("FAIL single_addr: got %0d address mismatches expected 0", am); end
    checks++; if (scan_lat != 6) begin errors++; $display("FAIL single_latency: got %0d expected 6", scan_lat); end
    checks++; if (scan_res !== 32'd2) begin errors++; $display("FAIL single_result: got %0d expected 2", scan_res); end
    checks++; if (scan_done_after !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b expected 0", scan_done_after); end
    checks++; if (scan_stray != 0) begin errors++; $display("FAIL single_stray: got %0d expected 0", scan_stray); end
    ci_cmd(CID, 1'b1, 2'd3, 32'd0, d, r);
    checks++; if (d !== 1'b1 || r !== 32'd2) begin errors++; $display("FAIL single_read: got done=%b res=%0d expected done=1 res=2", d, r); end
  endtask

  task automatic test_stall_multi();
    logic d; logic [31:0] r; logic [31:0] a; int am, exp_res;
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      mem_model[32'h1000 + 32'(4 * i)] = a;
      mem_model[32'h2000 + 32'(4 * i)] = (i == 2) ? (a ^ 32'h0101_0101 ^ {8'($urandom_range(0,254)) << 1, 8'h00, 8'h00, 8'h00} & 32'hFEFF_FFFF) : a;
    end
    mem_model[32'h2008] = mem_model[32'h1008] ^ 32'h8142_2418;
    exp_res = ref_diff(32'h1000, 32'h2000, 3);
    run_scan(3, 3, 1, 0, 0, 80);
    am = addr_mismatches(32'h1000, 32'h2000, 3);
    checks++; if (am != 0) begin errors++; $display("FAIL stall_addr: got %0d address mismatches expected 0", am); end
    checks++; if (scan_stall != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable request cycles expected 0", scan_stall); end
    checks++; if (scan_lat != ref_latency(3, 3, 1)) begin errors++; $display("FAIL stall_latency: got %0d expected %0d", scan_lat, ref_latency(3, 3, 1)); end
    checks++; if (scan_res !== 32'(exp_res) || exp_res != 4) begin errors++; $display("FAIL stall_result: got %0d expected 4", scan_res); end
    ci_cmd(CID, 1'b1, 2'd3, 32'd0, d, r);
    checks++; if (d !== 1'b1 || r !== 32'd4) begin errors++; $display("FAIL stall_read: got done=%b res=%0d expected done=1 res=4", d, r); end
  endtask

  task automatic test_zero_count();
    logic d; logic [31:0] r;
    run_scan(0, 0, 1, 0, 0, 20);
    checks++; if (addr_log.size() != 0) begin errors++; $display("FAIL zero_no_req: got %0d grants expected 0", addr_log.size()); end
    checks++; if (scan_lat != 1 || scan_res !== 32'h0) begin errors++; $display("FAIL zero_done: got lat=%0d res=%0d expected lat=1 res=0", scan_lat, scan_res); end
    ci_cmd(CID, 1'b1, 2'd3, 32'd0, d, r);
    checks++; if (d !== 1'b1 || r !== 32'h0) begin errors++; $display("FAIL zero_read: got done=%b res=%0d expected done=1 res=0", d, r); end
  endtask

  task automatic test_midscan_ignore();
    int am, exp_res;
    fill_random(32'h1000, 32'h2000, 2);
    exp_res = ref_diff(32'h1000, 32'h2000, 2);
    run_scan(2, 1, 3, 1, 0, 80);
    checks++; if (scan_inj_done !== 1'b0) begin errors++; $display("FAIL busy_set_done: got %b expected 0", scan_inj_done); end
    checks++; if (scan_res !== 32'(exp_res) || scan_lat != ref_latency(2, 1, 3)) begin errors++;
      $display("FAIL busy_scan: got res=%0d lat=%0d expected res=%0d lat=%0d", scan_res, scan_lat, exp_res, ref_latency(2, 1, 3)); end
    mem_model[32'h1000] = 32'hA5A5_0000;
    mem_model[32'h2000] = 32'h5AA5_0001;
    run_scan(1, 0, 1, 0, 0, 40);
    am = addr_mismatches(32'h1000, 32'h2000, 1);
    checks++; if (am != 0) begin errors++; $display("FAIL busy_base_kept: got %0d address mismatches expected 0", am); end
    checks++; if (scan_res !== 32'd2) begin errors++; $display("FAIL busy_followup: got %0d expected 2", scan_res); end
  endtask

  task automatic test_midscan_reset();
    logic d; logic [31:0] r;
    fill_random(32'h1000, 32'h2000, 2);
    run_scan(2, 0, 3, 1, 1, 60);
    checks++; if (scan_inj_done !== 1'b0) begin errors++; $display("FAIL abort_set_done: got %b expected 0", scan_inj_done); end
    checks++; if (scan_done !== 1'b0 || scan_post != 0) begin errors++;
      $display("FAIL abort_quiet: got done=%b active_cycles=%0d expected done=0 active_cycles=0", scan_done, scan_post); end
    ci_cmd(CID, 1'b1, 2'd3, 32'd0, d, r);
    checks++; if (d !== 1'b1 || r !== 32'h0) begin errors++; $display("FAIL abort_read: got done=%b res=%0d expected done=1 res=0", d, r); end
  endtask

  task automatic test_wrap();
    logic d; logic [31:0] r; int am, exp_res;
    ci_cmd(CID, 1'b1, 2'd0, 32'hFFFF_FFFC, d, r);
    ci_cmd(CID, 1'b1, 2'd1, 32'h0000_8000, d, r);
    fill_random(32'hFFFF_FFFC, 32'h0000_8000, 2);
    exp_res = ref_diff(32'hFFFF_FFFC, 32'h0000_8000, 2);
    run_scan(2, 0, 1, 0, 0, 40);
    am = addr_mismatches(32'hFFFF_FFFC, 32'h0000_8000, 2);
    checks++; if (am != 0 || addr_log[2] !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %0d mismatches expected 0", am); end
    checks++; if (scan_res !== 32'(exp_res)) begin errors++; $display("FAIL wrap_result: got %0d expected %0d", scan_res, exp_res); end
  endtask

  task automatic test_back_to_back();
    logic d; logic [31:0] r; logic [31:0] ba, bb; int am, exp_res, g, v;
    int unsigned n;
    for (int it = 0; it < 5; it++) begin
      ba = $urandom; bb = $urandom;
      n = $urandom_range(1, 5); g = $urandom_range(0, 3); v = $urandom_range(1, 3);
      ci_cmd(CID, 1'b1, 2'd0, ba, d, r);
      ci_cmd(CID, 1'b1, 2'd1, bb, d, r);
      ba[1:0] = 2'b00; bb[1:0] = 2'b00;
      fill_random(ba, bb, n);
      exp_res = ref_diff(ba, bb, n);
      run_scan(n, g, v, 0, 0, ref_latency(n, g, v) + 20);
      am = addr_mismatches(ba, bb, n);
      checks++; if (am != 0 || scan_stall != 0) begin errors++; $display("FAIL rand_addr[%0d]: got mismatches=%0d stalls=%0d expected 0", it, am, scan_stall); end
      checks++; if (scan_res !== 32'(exp_res) || scan_lat != ref_latency(n, g, v)) begin errors++;
        $display("FAIL rand_scan[%0d]: got res=%0d lat=%0d expected res=%0d lat=%0d", it, scan_res, scan_lat, exp_res, ref_latency(n, g, v)); end
      ci_cmd(CID, 1'b1, 2'd3, 32'd0, d, r);
      checks++; if (r !== 32'(exp_res)) begin errors++; $display("FAIL rand_read[%0d]: got %0d expected %0d", it, r, exp_res); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_set_regs();
    test_single_word();
    test_stall_multi();
    test_zero_count();
    test_midscan_ignore();
    test_midscan_reset();
    test_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
